alsu_param: RTL and testbench

//  Parametrised, handshaked arithmetic/logic/shift unit (next generation of the team's 3-bit ALSU).

---
 rtl/alsu_param.sv | 264 ++++++++++++++++++++++++++
 tb/tb_alsu_param.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_param.sv
// ============================================================================
// Module   : alsu_param
// Purpose  : Parametrised, handshaked arithmetic/logic/shift unit. Operands
//            are captured on an in_valid/in_ready handshake, the result is
//            registered one cycle later and flagged by a one-cycle out_valid
//            pulse. Illegal requests enter an ERROR state that blinks the LED
//            bank for BLINK_CYCLES cycles.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready          request handshake
//            A, B [WIDTH]                 operands
//            opcode [3]                   0 AND,1 XOR,2 ADD,3 MULT,4 SHIFT,
//                                         5 ROTATE, 6/7 illegal
//            cin, serial_in, direction    ADD carry, SHIFT fill, 1=left
//            red_op_A/B, bypass_A/B       reduction / bypass selects
//            out [2*WIDTH], out_valid, invalid, leds [LED_W]
// Options  : ALSU_MULTI_SHIFT_EN - SHIFT/ROTATE move B mod (2*WIDTH) bits,
//            one bit per cycle. Undefined: always a single-bit move.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alsu_param #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16,
    parameter int    BLINK_CYCLES   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 invalid,
    output logic [LED_W-1:0]     leds
);

    localparam int c_OW      = 2 * WIDTH;
    localparam int c_BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_CYCLES - 1);
    localparam logic c_PRIO_B   = (INPUT_PRIORITY == "B");
    localparam logic c_FULL_ADD = (FULL_ADDER == "ON");

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_XOR  = 3'd1;
    localparam logic [2:0] c_OP_ADD  = 3'd2;
    localparam logic [2:0] c_OP_MULT = 3'd3;
    localparam logic [2:0] c_OP_SHFT = 3'd4;
    localparam logic [2:0] c_OP_ROT  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t r_state, w_state_next;

    // Latched request
    logic [WIDTH-1:0] r_a, r_b;
    logic [2:0]       r_op;
    logic             r_cin, r_sin, r_dir;
    logic             r_red_a, r_red_b, r_byp_a, r_byp_b;

    // Outputs and counters
    logic [c_OW-1:0]      r_out;
    logic                 r_out_valid;
    logic                 r_invalid;
    logic [LED_W-1:0]     r_leds;
    logic [c_BLINK_W-1:0] r_blink_cnt;

    // Decode
    logic             w_illegal;
    logic             w_shift_op;
    logic [c_OW-1:0]  w_result;
    logic [c_OW-1:0]  w_step;
    logic [WIDTH:0]   w_sum;
    logic [c_OW-1:0]  w_prod;
    logic             w_byp_sel_b, w_red_sel_b, w_red_any;
    logic [WIDTH-1:0] w_byp_opnd, w_red_opnd;
    logic             w_exec_done;
    logic             w_out_hold;
    logic             w_blink_done;

`ifdef ALSU_MULTI_SHIFT_EN
    localparam int c_AMT_W = $clog2(c_OW);
    logic [c_AMT_W-1:0] r_shift_cnt;
    logic [c_AMT_W-1:0] w_amt;
    logic [31:0]        w_amt_full;

    assign w_amt_full  = 32'(B) % 32'(c_OW);
    assign w_amt       = w_amt_full[c_AMT_W-1:0];
    // A zero-length move still takes one EXEC cycle but leaves out untouched.
    assign w_out_hold  = w_shift_op && (r_shift_cnt == '0);
    assign w_exec_done = !w_shift_op || (r_shift_cnt <= c_AMT_W'(1));
`else
    assign w_out_hold  = 1'b0;
    assign w_exec_done = 1'b1;
`endif

    assign in_ready     = (r_state == S_IDLE);
    assign out          = r_out;
    assign out_valid    = r_out_valid;
    assign invalid      = r_invalid;
    assign leds         = r_leds;
    assign w_blink_done = (r_blink_cnt == c_BLINK_LAST);

    // When both flags of a pair are set, INPUT_PRIORITY picks the operand.
    assign w_byp_sel_b = r_byp_b & (~r_byp_a | c_PRIO_B);
    assign w_red_sel_b = r_red_b & (~r_red_a | c_PRIO_B);
    assign w_byp_opnd  = w_byp_sel_b ? r_b : r_a;
    assign w_red_opnd  = w_red_sel_b ? r_b : r_a;
    assign w_red_any   = r_red_a | r_red_b;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin & c_FULL_ADD};
    assign w_prod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Single-bit shift/rotate of the current result register
    always_comb begin
        w_step = r_out;
        if (r_op == c_OP_SHFT) begin
            w_step = r_dir ? {r_out[c_OW-2:0], r_sin} : {r_sin, r_out[c_OW-1:1]};
        end else begin
            w_step = r_dir ? {r_out[c_OW-2:0], r_out[c_OW-1]} : {r_out[0], r_out[c_OW-1:1]};
        end
    end

    // Decode on latched values, in priority order
    always_comb begin
        w_illegal  = 1'b0;
        w_shift_op = 1'b0;
        w_result   = r_out;
        if (r_op[2:1] == 2'b11) begin
            w_illegal = 1'b1;
        end else if (r_byp_a | r_byp_b) begin
            w_result = {{WIDTH{1'b0}}, w_byp_opnd};
        end else if (w_red_any && (r_op != c_OP_AND) && (r_op != c_OP_XOR)) begin
            w_illegal = 1'b1;
        end else begin
            case (r_op)
                c_OP_AND:  w_result = w_red_any ? {{(c_OW-1){1'b0}}, &w_red_opnd}
                                                : {{WIDTH{1'b0}}, r_a & r_b};
                c_OP_XOR:  w_result = w_red_any ? {{(c_OW-1){1'b0}}, ^w_red_opnd}
                                                : {{WIDTH{1'b0}}, r_a ^ r_b};
                c_OP_ADD:  w_result = {{(WIDTH-1){1'b0}}, w_sum};
                c_OP_MULT: w_result = w_prod;
                c_OP_SHFT, c_OP_ROT: begin
                    w_result   = w_step;
                    w_shift_op = 1'b1;
                end
                default:   w_result = r_out;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_illegal)        w_state_next = S_ERROR;
                else if (w_exec_done) w_state_next = S_IDLE;
            end
            S_ERROR: if (w_blink_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cin       <= 1'b0;
            r_sin       <= 1'b0;
            r_dir       <= 1'b0;
            r_red_a     <= 1'b0;
            r_red_b     <= 1'b0;
            r_byp_a     <= 1'b0;
            r_byp_b     <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_invalid   <= 1'b0;
            r_leds      <= '0;
            r_blink_cnt <= '0;
`ifdef ALSU_MULTI_SHIFT_EN
            r_shift_cnt <= '0;
`endif
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= opcode;
                        r_cin   <= cin;
                        r_sin   <= serial_in;
                        r_dir   <= direction;
                        r_red_a <= red_op_A;
                        r_red_b <= red_op_B;
                        r_byp_a <= bypass_A;
                        r_byp_b <= bypass_B;
`ifdef ALSU_MULTI_SHIFT_EN
                        r_shift_cnt <= w_amt;
`endif
                    end
                end
                S_EXEC: begin
                    if (w_illegal) begin
                        r_out       <= '0;
                        r_invalid   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_leds      <= '1;
                        r_blink_cnt <= '0;
                    end else begin
                        if (!w_out_hold) r_out <= w_result;
                        if (w_exec_done) begin
                            r_out_valid <= 1'b1;
                            r_invalid   <= 1'b0;
                        end
`ifdef ALSU_MULTI_SHIFT_EN
                        if (!w_exec_done) r_shift_cnt <= r_shift_cnt - c_AMT_W'(1);
`endif
                    end
                end
                S_ERROR: begin
                    if (w_blink_done) begin
                        r_leds <= '0;
                    end else begin
                        r_leds      <= ~r_leds;
                        r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
                    end
                end
                default: r_leds <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alsu_param.sv
// ============================================================================
// Module   : tb_alsu_param
// Purpose  : Directed self-checking bench for alsu_param (WIDTH=3, defaults).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alsu_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  A = '0, B = '0, opcode = '0;
    logic        cin = 1'b0, serial_in = 1'b0, direction = 1'b0;
    logic        red_op_A = 1'b0, red_op_B = 1'b0, bypass_A = 1'b0, bypass_B = 1'b0;
    logic [5:0]  out;
    logic        out_valid;
    logic        invalid;
    logic [15:0] leds;

    int vec_count = 0;
    int err_count = 0;

    alsu_param #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .cin       (cin),
        .serial_in (serial_in),
        .direction (direction),
        .red_op_A  (red_op_A),
        .red_op_B  (red_op_B),
        .bypass_A  (bypass_A),
        .bypass_B  (bypass_B),
        .out       (out),
        .out_valid (out_valid),
        .invalid   (invalid),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    // Present one request, let it be accepted, return 1ns into the result cycle.
    task automatic send(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic c, input logic s, input logic d,
                        input logic ra, input logic rb, input logic ba, input logic bb);
        opcode = op; A = a; B = b; cin = c; serial_in = s; direction = d;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        vec_count++; if (out !== 6'd0) begin err_count++; $display("FAIL reset_out: got %b want %b", out, 6'd0); end
        vec_count++; if (out_valid !== 1'b0) begin err_count++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vec_count++; if (invalid !== 1'b0) begin err_count++; $display("FAIL reset_invalid: got %b want 0", invalid); end
        vec_count++; if (leds !== 16'h0000) begin err_count++; $display("FAIL reset_leds: got %h want 0000", leds); end
        vec_count++; if (in_ready !== 1'b1) begin err_count++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_and_bypass;
        send(3'd0, 3'b101, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b000001) begin err_count++; $display("FAIL and_bitwise: got %b want %b", out, 6'b000001); end
        vec_count++; if (out_valid !== 1'b1) begin err_count++; $display("FAIL and_out_valid: got %b want 1", out_valid); end
        vec_count++; if (invalid !== 1'b0) begin err_count++; $display("FAIL and_invalid: got %b want 0", invalid); end
        @(posedge clk); #1;
        vec_count++; if (out_valid !== 1'b0) begin err_count++; $display("FAIL and_pulse_width: got %b want 0", out_valid); end
        vec_count++; if (out !== 6'b000001) begin err_count++; $display("FAIL and_hold: got %b want %b", out, 6'b000001); end
        send(3'd0, 3'b101, 3'b011, 0, 0, 0, 0, 0, 1, 1);
        vec_count++; if (out !== 6'b000101) begin err_count++; $display("FAIL bypass_both: got %b want %b", out, 6'b000101); end
        vec_count++; if (invalid !== 1'b0) begin err_count++; $display("FAIL bypass_invalid: got %b want 0", invalid); end
        send(3'd1, 3'b101, 3'b011, 0, 0, 0, 0, 0, 0, 1);
        vec_count++; if (out !== 6'b000011) begin err_count++; $display("FAIL bypass_b: got %b want %b", out, 6'b000011); end
        send(3'd1, 3'b100, 3'b011, 0, 0, 0, 1, 0, 0, 0);
        vec_count++; if (out !== 6'b000001) begin err_count++; $display("FAIL xor_reduce_a: got %b want %b", out, 6'b000001); end
        send(3'd0, 3'b111, 3'b010, 0, 0, 0, 1, 1, 0, 0);
        vec_count++; if (out !== 6'b000001) begin err_count++; $display("FAIL and_reduce_prio: got %b want %b", out, 6'b000001); end
    endtask

    task automatic test_add_mult;
        send(3'd2, 3'b101, 3'b011, 1, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b001001) begin err_count++; $display("FAIL add_cin: got %b want %b", out, 6'b001001); end
        vec_count++; if (out_valid !== 1'b1) begin err_count++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        vec_count++; if (in_ready !== 1'b1) begin err_count++; $display("FAIL add_ready_n1: got %b want 1", in_ready); end
        @(posedge clk); #1;
        vec_count++; if (out_valid !== 1'b0) begin err_count++; $display("FAIL add_pulse_width: got %b want 0", out_valid); end
        send(3'd3, 3'b111, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b110001) begin err_count++; $display("FAIL mult_max: got %b want %b", out, 6'b110001); end
        send(3'd2, 3'b111, 3'b111, 1, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b001111) begin err_count++; $display("FAIL add_max: got %b want %b", out, 6'b001111); end
    endtask

    task automatic test_shift_rotate;
        send(3'd2, 3'b101, 3'b011, 1, 0, 0, 0, 0, 0, 0);
        send(3'd4, 3'b000, 3'b001, 0, 1, 1, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b010011) begin err_count++; $display("FAIL shift_left: got %b want %b", out, 6'b010011); end
        send(3'd5, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b101001) begin err_count++; $display("FAIL rotate_right: got %b want %b", out, 6'b101001); end
        send(3'd4, 3'b000, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b010100) begin err_count++; $display("FAIL shift_right: got %b want %b", out, 6'b010100); end
        send(3'd0, 3'b001, 3'b000, 0, 0, 0, 0, 0, 1, 0);
`ifdef ALSU_MULTI_SHIFT_EN
        opcode = 3'd5; A = 3'b000; B = 3'b011; direction = 1'b1; bypass_A = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        vec_count++; if (out !== 6'b000010 || out_valid !== 1'b0) begin err_count++; $display("FAIL multi_rot_c1: got %b/%b want 000010/0", out, out_valid); end
        @(posedge clk); #1;
        vec_count++; if (out !== 6'b000100 || out_valid !== 1'b0) begin err_count++; $display("FAIL multi_rot_c2: got %b/%b want 000100/0", out, out_valid); end
        @(posedge clk); #1;
        vec_count++; if (out !== 6'b001000 || out_valid !== 1'b1) begin err_count++; $display("FAIL multi_rot_c3: got %b/%b want 001000/1", out, out_valid); end
        @(posedge clk); #1;
        vec_count++; if (out_valid !== 1'b0) begin err_count++; $display("FAIL multi_rot_after: got %b want 0", out_valid); end
`else
        send(3'd5, 3'b000, 3'b011, 0, 0, 1, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b000010) begin err_count++; $display("FAIL rotate_b_ignored: got %b want %b", out, 6'b000010); end
`endif
    endtask

    task automatic test_illegal;
        logic [15:0] exp_leds;
        send(3'd0, 3'b101, 3'b000, 0, 0, 0, 0, 0, 1, 0);
        vec_count++; if (out !== 6'b000101) begin err_count++; $display("FAIL ill_setup: got %b want %b", out, 6'b000101); end
        send(3'd6, 3'b101, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'd0) begin err_count++; $display("FAIL ill_out: got %b want 000000", out); end
        vec_count++; if (invalid !== 1'b1) begin err_count++; $display("FAIL ill_invalid: got %b want 1", invalid); end
        vec_count++; if (out_valid !== 1'b1) begin err_count++; $display("FAIL ill_out_valid: got %b want 1", out_valid); end
        vec_count++; if (leds !== 16'hFFFF) begin err_count++; $display("FAIL ill_leds_c1: got %h want FFFF", leds); end
        // A legal request held during ERROR must be ignored.
        opcode = 3'd0; A = 3'b111; B = 3'b111; in_valid = 1'b1;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk); #1;
            exp_leds = (i % 2 == 1) ? 16'h0000 : 16'hFFFF;
            vec_count++; if (leds !== exp_leds || in_ready !== 1'b0 || out_valid !== 1'b0)
                begin err_count++; $display("FAIL ill_blink_c%0d: got leds=%h rdy=%b ov=%b want leds=%h rdy=0 ov=0", i + 1, leds, in_ready, out_valid, exp_leds); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vec_count++; if (leds !== 16'h0000 || in_ready !== 1'b1) begin err_count++; $display("FAIL ill_exit: got leds=%h rdy=%b want 0000/1", leds, in_ready); end
        vec_count++; if (out !== 6'd0 || out_valid !== 1'b0) begin err_count++; $display("FAIL ill_ignored: got out=%b ov=%b want 000000/0", out, out_valid); end

        send(3'd0, 3'b000, 3'b110, 0, 0, 0, 0, 0, 0, 1);
        send(3'd2, 3'b001, 3'b001, 0, 0, 0, 1, 0, 0, 0);
        vec_count++; if (out !== 6'd0 || invalid !== 1'b1 || leds !== 16'hFFFF)
            begin err_count++; $display("FAIL red_add_illegal: got out=%b inv=%b leds=%h want 000000/1/FFFF", out, invalid, leds); end
        repeat (6) begin @(posedge clk); #1; end
        vec_count++; if (in_ready !== 1'b1 || leds !== 16'h0000) begin err_count++; $display("FAIL red_exit: got rdy=%b leds=%h want 1/0000", in_ready, leds); end
        send(3'd0, 3'b110, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b000010 || invalid !== 1'b0) begin err_count++; $display("FAIL ill_recover: got out=%b inv=%b want 000010/0", out, invalid); end
    endtask

    task automatic test_async_reset;
        send(3'd7, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        vec_count++; if (leds !== 16'hFFFF) begin err_count++; $display("FAIL rst_pre_c3: got %h want FFFF", leds); end
        #2 rst_n = 1'b0;
        #1;
        vec_count++; if (leds !== 16'h0000 || out !== 6'd0 || invalid !== 1'b0)
            begin err_count++; $display("FAIL rst_async: got leds=%h out=%b inv=%b want 0000/000000/0", leds, out, invalid); end
        vec_count++; if (in_ready !== 1'b1) begin err_count++; $display("FAIL rst_async_idle: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(3'd3, 3'b010, 3'b011, 0, 0, 0, 0, 0, 0, 0);
        vec_count++; if (out !== 6'b000110 || out_valid !== 1'b1) begin err_count++; $display("FAIL rst_first_req: got %b/%b want 000110/1", out, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [2:0] op_t [4] = '{3'd2, 3'd3, 3'd1, 3'd0};
        logic [2:0] a_t  [4] = '{3'b001, 3'b011, 3'b110, 3'b000};
        logic [2:0] b_t  [4] = '{3'b010, 3'b011, 3'b011, 3'b111};
        logic       bb_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [5:0] ex_t [4] = '{6'b000011, 6'b001001, 6'b000101, 6'b000111};
        int idx = 0, k = 0, last_acc = -1;
        logic rdy;
        cin = 0; serial_in = 0; direction = 0; red_op_A = 0; red_op_B = 0; bypass_A = 0;
        opcode = op_t[0]; A = a_t[0]; B = b_t[0]; bypass_B = bb_t[0];
        in_valid = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy && in_valid) begin
                if (last_acc >= 0) begin
                    vec_count++; if (i - last_acc != 2) begin err_count++; $display("FAIL b2b_spacing: got %0d want 2", i - last_acc); end
                end
                last_acc = i;
                idx++;
                if (idx < 4) begin
                    opcode = op_t[idx]; A = a_t[idx]; B = b_t[idx]; bypass_B = bb_t[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                vec_count++; if (out !== ex_t[k]) begin err_count++; $display("FAIL b2b_result%0d: got %b want %b", k, out, ex_t[k]); end
                k++;
            end
        end
        in_valid = 1'b0;
        vec_count++; if (k != 4) begin err_count++; $display("FAIL b2b_pulses: got %0d want 4", k); end
    endtask

    initial begin
        test_reset();
        test_and_bypass();
        test_add_mult();
        test_shift_rotate();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

`default_nettype wire
